serializador_de_palavra: RTL and testbench

- Upstream feeder for the 4-bit serial-in/parallel-out shift register.
- Accepts parallel words over a valid/ready handshake and drives them out one bit per clock, LSB first, so each word lands in the downstream register with word bit i at data_out[i].
- A one-entry holding buffer allows gapless back-to-back streaming.
- A strobe marks the cycle in which the downstream register holds a complete, aligned word.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/serializador_de_palavra_buffer.sv | 49 ++++
 rtl/serializador_de_palavra.sv | 126 ++++++++++++
 tb/tb_serializador_de_palavra.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_pkg
// Description : Shared definitions for the word serializer and for the
//               downstream serial-in/parallel-out shift register it feeds.
//               Both sides must use the same NBITS_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Word width. It must match the downstream register width and be >= 2.
  localparam int NBITS_DATA = 4;
  // Width of the bit counter. Derived from NBITS_DATA; do not override.
  localparam int CNT_W      = $clog2(NBITS_DATA);

  typedef logic [NBITS_DATA-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serializador_de_palavra_buffer.sv
`default_nettype none
// ============================================================================
// Module      : buffer_palavra
// Description : One-entry holding register for a word. It is written by
//               push_i and emptied by pop_i. The owner guarantees that push_i
//               is only asserted while the buffer is empty.
// Ports       : clk     - system clock
//               reset   - asynchronous active-low reset
//               push_i  - store data_i and mark the buffer full
//               pop_i   - release the stored word
//               data_i  - word to store
//               data_o  - stored word
//               full_o  - buffer holds a word
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_palavra
  import serial_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push_i,
  input  logic  pop_i,
  input  word_t data_i,
  output word_t data_o,
  output logic  full_o
);

  word_t data_q;
  logic  full_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (push_i) begin
        data_q <= data_i;
        full_q <= 1'b1;
      end else if (pop_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule : buffer_palavra
`default_nettype wire

// File: rtl/serializador_de_palavra.sv
`default_nettype none
// ============================================================================
// Module      : serializador_de_palavra
// Description : Accepts parallel words over a valid/ready handshake and sends
//               them out one bit per clock, LSB first. Each word ends up in
//               the downstream shift register with word bit i at
//               data_out[i]. A one-entry holding buffer lets words stream
//               back to back without gaps. word_aligned pulses for one cycle
//               while the downstream register holds a complete word.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous active-low reset
//               in_data      - parallel word to transmit
//               in_valid     - in_data is valid
//               in_ready     - a word can be accepted this cycle
//               serial_out   - serial bit (downstream data_in)
//               serial_valid - serial_out carries a word bit
//               word_aligned - downstream register holds the last word
//               busy         - shifter or holding buffer is occupied
// Revision    : 1.0 - initial release
// ============================================================================
module serializador_de_palavra
  import serial_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NBITS_DATA-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  word_aligned,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS_DATA - 1);

  state_t           state_q;
  word_t            shifter_q;
  logic [CNT_W-1:0] cnt_q;
  logic             serial_out_q;
  logic             serial_valid_q;
  logic             word_aligned_q;

  word_t            hold_data;
  logic             hold_full;

  logic             xfer;
  logic             last_bit;
  logic             hold_push;
  logic             hold_pop;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready  = !hold_full;
  assign xfer      = in_valid && in_ready;
  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  // Words arriving mid-word are parked. On the last-bit edge the word
  // bypasses the buffer straight into the shifter instead.
  assign hold_push = xfer && (state_q == SHIFT) && !last_bit;
  assign hold_pop  = last_bit && hold_full;

  buffer_palavra u_hold (
    .clk    (clk),
    .reset  (reset),
    .push_i (hold_push),
    .pop_i  (hold_pop),
    .data_i (in_data),
    .data_o (hold_data),
    .full_o (hold_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      shifter_q      <= '0;
      cnt_q          <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      word_aligned_q <= 1'b0;
    end else begin
      // The downstream register samples bit N-1 on the last-bit edge, so the
      // strobe appears in the cycle that follows that edge.
      word_aligned_q <= last_bit;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q        <= SHIFT;
            shifter_q      <= in_data;
            cnt_q          <= '0;
            serial_out_q   <= in_data[0];
            serial_valid_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shifter_q    <= shifter_q >> 1;
            serial_out_q <= shifter_q[1];
            cnt_q        <= cnt_q + CNT_ONE;
          end else if (hold_full) begin
            shifter_q    <= hold_data;
            serial_out_q <= hold_data[0];
            cnt_q        <= '0;
          end else if (xfer) begin
            shifter_q    <= in_data;
            serial_out_q <= in_data[0];
            cnt_q        <= '0;
          end else begin
            state_q        <= IDLE;
            shifter_q      <= '0;
            cnt_q          <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign word_aligned = word_aligned_q;
  assign busy         = (state_q == SHIFT) || hold_full;

endmodule : serializador_de_palavra
`default_nettype wire

// File: tb/tb_serializador_de_palavra.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializador_de_palavra
// Description : Scoreboard bench for serializador_de_palavra. Each accepted
//               word queues its expected serial bits and the expected
//               downstream register contents. A monitor pops and compares
//               them whenever serial_valid or word_aligned is high. The
//               downstream SIPO register is modelled locally.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializador_de_palavra;

  logic       clk;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       serial_out;
  logic       serial_valid;
  logic       word_aligned;
  logic       busy;

  logic [3:0] ds_q;       // downstream shift register model
  logic       exp_bits[$];
  logic [3:0] exp_words[$];

  int n_cmp    = 0;
  int n_fail   = 0;
  int run      = 0;
  int max_run  = 0;
  int strobes  = 0;

  serializador_de_palavra dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .word_aligned (word_aligned),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream SIPO: shifts right with data_in entering at the MSB, so after
  // N LSB-first bits, word bit i sits at data_out[i].
  always @(posedge clk or negedge reset) begin
    if (!reset)            ds_q <= 4'h0;
    else if (serial_valid) ds_q <= {serial_out, ds_q[3:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every serial bit and every strobe against the queues.
  always @(negedge clk) begin
    if (reset) begin
      if (serial_valid) begin
        run++;
        if (exp_bits.size() == 0) fail_now("unexpected_serial_bit");
        else chk("serial_bit", 32'(serial_out), 32'(exp_bits.pop_front()));
      end else begin
        run = 0;
        chk("idle_serial_out", 32'(serial_out), 32'd0);
      end
      if (run > max_run) max_run = run;
      if (word_aligned) begin
        strobes++;
        if (exp_words.size() == 0) fail_now("unexpected_word_aligned");
        else chk("downstream_word", 32'(ds_q), 32'(exp_words.pop_front()));
      end
    end
  end

  // Called right after a falling edge; returns right after the falling edge
  // that follows the transfer edge.
  task automatic send(input logic [3:0] w);
    bit done = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        for (int b = 0; b < 4; b++) exp_bits.push_back(w[b]);
        exp_words.push_back(w);
        @(negedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      if (!busy && !serial_valid) idle = 1;
      else @(negedge clk);
    end
    if (!idle) fail_now("wait_idle_timeout");
    repeat (2) @(negedge clk);
    chk("pending_words", 32'(exp_words.size()), 32'd0);
  endtask

  int s0;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    #3;
    chk("rst_serial_valid", 32'(serial_valid), 32'd0);
    chk("rst_serial_out",   32'(serial_out),   32'd0);
    chk("rst_word_aligned", 32'(word_aligned), 32'd0);
    chk("rst_busy",         32'(busy),         32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // 1: single word
    s0 = strobes;
    send(4'b1011);
    for (int i = 0; i < 3; i++) begin
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    wait_idle();
    chk("t1_strobes", 32'(strobes - s0), 32'd1);

    // 2: continuous streaming
    max_run = 0; s0 = strobes;
    send(4'hA); send(4'h5); send(4'hF);
    wait_idle();
    chk("t2_gapless_run", 32'(max_run), 32'd12);
    chk("t2_strobes", 32'(strobes - s0), 32'd3);

    // 3: hold full back-pressure
    max_run = 0;
    send(4'h1); send(4'h2);
    chk("t3_in_ready_held", 32'(in_ready), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    send(4'hC);
    wait_idle();
    chk("t3_gapless_run", 32'(max_run), 32'd12);

    // 4: bypass on the last-bit edge
    max_run = 0;
    send(4'h7);
    repeat (3) @(negedge clk);
    send(4'h8);
    wait_idle();
    chk("t4_gapless_run", 32'(max_run), 32'd8);

    // 5: asynchronous reset mid-word with a word held
    s0 = strobes;
    send(4'h6); send(4'h9);
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_bits.delete();
    exp_words.delete();
    #1;
    chk("t5_serial_valid", 32'(serial_valid), 32'd0);
    chk("t5_serial_out",   32'(serial_out),   32'd0);
    chk("t5_busy",         32'(busy),         32'd0);
    chk("t5_in_ready",     32'(in_ready),     32'd1);
    chk("t5_word_aligned", 32'(word_aligned), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(4'h3);
    wait_idle();
    chk("t5_strobes", 32'(strobes - s0), 32'd1);

    // 6: words separated by idle gaps
    max_run = 0;
    begin
      logic [3:0] gap_words [3];
      gap_words[0] = 4'hE; gap_words[1] = 4'h1; gap_words[2] = 4'h4;
      for (int k = 0; k < 3; k++) begin
        send(gap_words[k]);
        chk("t6_busy_active", 32'(busy), 32'd1);
        wait_idle();
        chk("t6_busy_idle", 32'(busy), 32'd0);
        chk("t6_serial_valid_idle", 32'(serial_valid), 32'd0);
        @(negedge clk);
      end
    end
    chk("t6_max_run", 32'(max_run), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serializador_de_palavra
`default_nettype wire
